// File: rtl/left_iter_if.sv
// ---------------------------------------------------------------------------
// left_iter_if
//   Request/result bundle of the multi-cycle left shifter/rotator.
//
//   Start  : request, accepted when Ready is high at a rising edge
//   In     : operand, sampled on accept
//   ShAmt  : shift amount 0..2^SHW-1, sampled on accept
//   Rot    : 0 = shift left logical (zero fill), 1 = rotate left
//   Ready  : high only while the shifter is idle
//   Done   : one-cycle pulse when Out/Cout hold a new result
//   Out    : result register, held until the next accept
//   Cout   : last bit moved out of the top position (0 for ShAmt = 0)
//
//   master : the requester (drives Start/In/ShAmt/Rot)
//   slave  : the shifter   (drives Ready/Done/Out/Cout)
// ---------------------------------------------------------------------------
interface left_iter_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             Start;
    logic [WIDTH-1:0] In;
    logic [SHW-1:0]   ShAmt;
    logic             Rot;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Out;
    logic             Cout;

    modport master (
        output Start, In, ShAmt, Rot,
        input  Ready, Done, Out, Cout
    );

    modport slave (
        input  Start, In, ShAmt, Rot,
        output Ready, Done, Out, Cout
    );
endinterface

// File: rtl/left_iter.sv
// ---------------------------------------------------------------------------
// left_iter
//   Multi-cycle left shifter/rotator for the ALU shift path. One bit position
//   is moved per clock (two with LEFT_ITER_RADIX4_EN), avoiding a full
//   combinational left barrel shifter in the execute stage.
//
//   Ports:
//     clk  : clock, all state updates on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : left_iter_if.slave (Start/In/ShAmt/Rot in, Ready/Done/Out/Cout out)
//
//   Build option:
//     LEFT_ITER_RADIX4_EN : when defined, each busy step moves two positions
//                           while at least two remain. Out and Cout are the
//                           same as in the default build; only latency drops.
//
//   States: IDLE (Ready=1) -> BUSY (shifting) -> DONE (Done=1) -> IDLE.
//   Ready and Done are decoded from the state register only, and Out/Cout
//   are registers, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module left_iter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    left_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
`ifdef LEFT_ITER_RADIX4_EN
    localparam logic [SHW-1:0] CNT_TWO  = {{(SHW-2){1'b0}}, 2'b10};
`endif

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] work_r;
    logic [SHW-1:0]   cnt_r;
    logic             mode_r;
    logic             cout_r;

    logic [WIDTH-1:0] step_work_s;
    logic [SHW-1:0]   step_cnt_s;
    logic             step_cout_s;

    logic             ready_s;
    logic             done_s;

    // One-position left move; the vacated LSB takes the old MSB on rotate.
    function automatic logic [WIDTH-1:0] shl1(input logic [WIDTH-1:0] w,
                                              input logic             rot);
        logic fill;
        fill = rot ? w[WIDTH-1] : 1'b0;
        return {w[WIDTH-2:0], fill};
    endfunction

`ifdef LEFT_ITER_RADIX4_EN
    // Two-position left move; on rotate the two top bits wrap in order.
    function automatic logic [WIDTH-1:0] shl2(input logic [WIDTH-1:0] w,
                                              input logic             rot);
        logic [1:0] fill;
        fill = rot ? w[WIDTH-1:WIDTH-2] : 2'b00;
        return {w[WIDTH-3:0], fill};
    endfunction
`endif

    // Next working value, carry and remaining count for one busy step.
    always_comb begin
        step_work_s = work_r;
        step_cnt_s  = cnt_r;
        step_cout_s = cout_r;
`ifdef LEFT_ITER_RADIX4_EN
        if (cnt_r >= CNT_TWO) begin
            // The bit that leaves last in a two-position move is the one
            // just below the MSB, so it becomes the carry.
            step_work_s = shl2(work_r, mode_r);
            step_cout_s = work_r[WIDTH-2];
            step_cnt_s  = cnt_r - CNT_TWO;
        end else begin
            step_work_s = shl1(work_r, mode_r);
            step_cout_s = work_r[WIDTH-1];
            step_cnt_s  = cnt_r - CNT_ONE;
        end
`else
        step_work_s = shl1(work_r, mode_r);
        step_cout_s = work_r[WIDTH-1];
        step_cnt_s  = cnt_r - CNT_ONE;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    // A zero amount needs no shift step at all.
                    if (bus.ShAmt == CNT_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (step_cnt_s == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a safe idle state.
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs, decoded from the state register only.
    always_comb begin
        ready_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                done_s  = 1'b0;
            end
            ST_BUSY: begin
                ready_s = 1'b0;
                done_s  = 1'b0;
            end
            ST_DONE: begin
                ready_s = 1'b0;
                done_s  = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Working register, count, mode and carry: load on accept, step in BUSY,
    // hold otherwise so the result stays visible through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r <= {WIDTH{1'b0}};
            cnt_r  <= CNT_ZERO;
            mode_r <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.Start) begin
                        work_r <= bus.In;
                        cnt_r  <= bus.ShAmt;
                        mode_r <= bus.Rot;
                        cout_r <= 1'b0;
                    end else begin
                        work_r <= work_r;
                        cnt_r  <= cnt_r;
                        mode_r <= mode_r;
                        cout_r <= cout_r;
                    end
                end
                ST_BUSY: begin
                    work_r <= step_work_s;
                    cnt_r  <= step_cnt_s;
                    mode_r <= mode_r;
                    cout_r <= step_cout_s;
                end
                default: begin
                    work_r <= work_r;
                    cnt_r  <= cnt_r;
                    mode_r <= mode_r;
                    cout_r <= cout_r;
                end
            endcase
        end
    end

    assign bus.Ready = ready_s;
    assign bus.Done  = done_s;
    assign bus.Out   = work_r;
    assign bus.Cout  = cout_r;

endmodule

// File: tb/tb_left_iter.sv
// ---------------------------------------------------------------------------
// tb_left_iter
//   Directed vectors with hand-computed results for left_iter. Inputs are
//   driven on the falling edge; outputs are sampled 1 time unit after the
//   rising edge. Latency is counted in cycles from the accepting edge, so a
//   Done seen right after the accept edge has latency 1.
// ---------------------------------------------------------------------------
module tb_left_iter;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    left_iter_if #(.WIDTH(16), .SHW(4)) bus ();

    left_iter #(.WIDTH(16), .SHW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected Done latency in cycles after the accepting edge.
    function automatic int lat_of(input int sh);
`ifdef LEFT_ITER_RADIX4_EN
        return (sh + 1) / 2 + 1;
`else
        return sh + 1;
`endif
    endfunction

    // Present a request in the cycle before an edge; return 1 unit after
    // the accepting edge with Start dropped.
    task automatic start_op(input string tag, input logic [15:0] din,
                            input logic [3:0] sh, input logic rot);
        @(negedge clk);
        check_val({tag, "_ready_pre"}, {31'd0, bus.Ready}, 32'd1);
        bus.Start = 1'b1;
        bus.In    = din;
        bus.ShAmt = sh;
        bus.Rot   = rot;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Wait (bounded) for Done, then check latency, result, and the return
    // to Ready in the following cycle.
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [15:0] exp_out, input logic exp_cout);
        int lat;
        lat = 1;
        if (exp_lat > 1) begin
            check_val({tag, "_ready_busy"}, {31'd0, bus.Ready}, 32'd0);
        end
        while (bus.Done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"},  lat, exp_lat);
        check_val({tag, "_out"},  {16'd0, bus.Out}, {16'd0, exp_out});
        check_val({tag, "_cout"}, {31'd0, bus.Cout}, {31'd0, exp_cout});
        check_val({tag, "_ready_done"}, {31'd0, bus.Ready}, 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, "_ready_after"}, {31'd0, bus.Ready}, 32'd1);
        check_val({tag, "_done_after"},  {31'd0, bus.Done},  32'd0);
    endtask

    initial begin
        int dones;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.In    = 16'h0000;
        bus.ShAmt = 4'd0;
        bus.Rot   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", {31'd0, bus.Ready}, 32'd1);
        check_val("rst_done",  {31'd0, bus.Done},  32'd0);
        check_val("rst_out",   {16'd0, bus.Out},   32'h0000);
        check_val("rst_cout",  {31'd0, bus.Cout},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // SLL by 1: MSB goes to carry.
        start_op("sll1", 16'h8001, 4'd1, 1'b0);
        wait_done("sll1", lat_of(1), 16'h0002, 1'b1);
        // Result held through idle.
        repeat (3) @(posedge clk);
        #1;
        check_val("hold_out", {16'd0, bus.Out}, 32'h0002);

        // ROL by 4.
        start_op("rol4", 16'h8001, 4'd4, 1'b1);
        wait_done("rol4", lat_of(4), 16'h0018, 1'b0);

        // Zero amount: straight to DONE, carry cleared.
        start_op("sh0", 16'hA5A5, 4'd0, 1'b0);
        wait_done("sh0", lat_of(0), 16'hA5A5, 1'b0);

        // Even amount: carry comes from the bit below the MSB in radix-4.
        start_op("sll2", 16'h4000, 4'd2, 1'b0);
        wait_done("sll2", lat_of(2), 16'h0000, 1'b1);

        // Odd amount ending in a single step.
        start_op("sll9", 16'h00FF, 4'd9, 1'b0);
        wait_done("sll9", lat_of(9), 16'hFE00, 1'b1);

        // ROL by 15 equals rotate right by 1.
        start_op("rol15", 16'h8001, 4'd15, 1'b1);
        wait_done("rol15", lat_of(15), 16'hC000, 1'b0);

        // Max SLL with a second request held high throughout BUSY.
        start_op("sll15", 16'hFFFF, 4'd15, 1'b0);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.In    = 16'h1234;
        bus.ShAmt = 4'd3;
        bus.Rot   = 1'b1;
        wait_done("sll15", lat_of(15), 16'h8000, 1'b1);
        // Now idle with Start still high: accepted at the next edge.
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        wait_done("held", lat_of(3), 16'h91A0, 1'b0);

        // Reset during an operation aborts it with no Done.
        start_op("abort", 16'h00FF, 4'd8, 1'b0);
        check_val("abort_done_n1", {31'd0, bus.Done}, 32'd0);
        @(posedge clk);
        #1;
        check_val("abort_done_n2", {31'd0, bus.Done}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_ready", {31'd0, bus.Ready}, 32'd1);
        check_val("abort_out",   {16'd0, bus.Out},   32'h0000);
        check_val("abort_cout",  {31'd0, bus.Cout},  32'd0);
        check_val("abort_done",  {31'd0, bus.Done},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.Done === 1'b1) dones++;
        end
        check_val("abort_no_done", dones, 32'd0);

        // Reset and Start together: reset wins, request dropped.
        @(negedge clk);
        rst       = 1'b1;
        bus.Start = 1'b1;
        bus.In    = 16'hFFFF;
        bus.ShAmt = 4'd0;
        bus.Rot   = 1'b0;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        check_val("rs_ready", {31'd0, bus.Ready}, 32'd1);
        check_val("rs_done",  {31'd0, bus.Done},  32'd0);
        check_val("rs_out",   {16'd0, bus.Out},   32'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rs_done_next", {31'd0, bus.Done}, 32'd0);
        check_val("rs_out_next",  {16'd0, bus.Out},  32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/left_iter.md
# left_iter

Multi-cycle left shifter/rotator for the ALU shift path. It is the left-direction counterpart of the combinational right shifter.
- Accepts a 16-bit operand and a 4-bit amount through a start/ready handshake.
- Shifts one bit position per clock, or two with the radix-4 option.
- Raises a one-cycle `Done` with the result held in a register.
- Supports SLL (zero-fill) and ROL (rotate). Used where a full combinational left barrel shifter would lengthen the execute critical path.

## Interface
- `WIDTH`, 16, operand/result width.
- `SHW`, 4, shift-amount width; must satisfy 2^SHW = WIDTH.
- `clk` in 1: clock. All state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Start` in 1: request. Accepted only when `Ready`=1 at the rising edge.
- `In` in WIDTH: operand. Sampled on accept.
- `ShAmt` in SHW: shift amount 0..15. Sampled on accept.
- `Rot` in 1: 0 = shift left logical (zero fill), 1 = rotate left. Sampled on accept.
- `Ready` out 1: high only in IDLE.
- `Done` out 1: one-cycle pulse when `Out`/`Cout` hold a new result.
- `Out` out WIDTH: result register. Holds its value until the next accept updates it.
- `Cout` out 1: bit 15 of the working value just before the final shift step; 0 if `ShAmt`=0.

## Operation
- FSM states: IDLE, BUSY, DONE. State is encoded in registers; outputs are decoded from state and registers only (no input-to-output combinational path).
- IDLE:
  - `Ready`=1.
  - On `Start`=1: load work reg ← `In`, cnt ← `ShAmt`, mode ← `Rot`, `Cout` ← 0.
  - Go to BUSY if `ShAmt`≠0, else DONE.
  - `Start`=0: stay in IDLE.
- BUSY, each clock:
  - SLL: work ← {work[14:0],0}.
  - ROL: work ← {work[14:0],work[15]}.
  - `Cout` ← work[15].
  - cnt ← cnt−1.
  - Go to DONE when the decremented cnt = 0.
  - `Start` is ignored (`Ready`=0).
- DONE: `Done`=1, `Ready`=0. Next state is IDLE unconditionally.
- `Out` is the work register itself; it is valid whenever `Done`=1 and is held through IDLE.
- No overflow or sign handling. Bits shifted out in SLL are discarded except the last, which is reported on `Cout`.
- Reset in any state:
  - State ← IDLE.
  - `Out`=0, `Cout`=0, cnt=0, `Done`=0; `Ready`=1 from the first cycle after reset.
  - An in-flight operation is aborted with no `Done`.
- Simultaneous `rst` and `Start`: reset wins and the request is dropped.

## Timing
- Start accepted at edge of cycle N; `Done` high during cycle N+ShAmt+1.
  - `ShAmt`=0: `Done` in N+1.
  - `ShAmt`=15: `Done` in N+16.
- `Ready` returns high in the cycle after `Done`. Back-to-back period is ShAmt+2 cycles.
- `Out` and `Cout` change only on edges in BUSY or on accept, or on reset. They are stable throughout the DONE cycle.
- Reset values: `Ready`=1, `Done`=0, `Out`=16'h0000, `Cout`=0.

## Configuration
- `LEFT_ITER_RADIX4_EN` defined:
  - Each BUSY step shifts 2 positions when cnt≥2; cnt decrements by 2.
  - Shifts 1 position when cnt=1.
  - `Cout` = work[15] of the value before the final single-position move. For a 2-bit step, that is the bit that ends up last out: work[14] before the step.
  - Latency: `Done` in cycle N+ceil(ShAmt/2)+1.
- Undefined: 1 position per step, latency as in Timing.
- Results (`Out`, `Cout`) are identical in both builds.

## Test plan
- `In`=16'h8001, `ShAmt`=1, `Rot`=0, `Start` at N -> `Done` in N+2, `Out`=16'h0002, `Cout`=1.
- `In`=16'h8001, `ShAmt`=4, `Rot`=1 -> `Out`=16'h0018, `Cout`=0.
  - `Done` in N+5; N+3 with `LEFT_ITER_RADIX4_EN`.
- `In`=16'hA5A5, `ShAmt`=0, `Rot`=0 -> `Done` in N+1, `Out`=16'hA5A5, `Cout`=0. `Ready` is 0 in N+1 and 1 in N+2.
- `In`=16'hFFFF, `ShAmt`=15, `Rot`=0 -> `Out`=16'h8000, `Cout`=1.
  - `Done` in N+16; N+9 with `LEFT_ITER_RADIX4_EN`.
  - Second `Start` with `In`=16'h1234 held high during BUSY is ignored: `Out` stays 16'h8000.
  - The second request is accepted only once `Ready`=1.
- Start `In`=16'h00FF, `ShAmt`=8, then `rst`=1 at N+3 -> next cycle `Ready`=1, `Out`=16'h0000, `Cout`=0, and no `Done` pulse occurs.
